// File: rtl/fetch_sequencer.sv
// fetch_sequencer: PC owner and single-outstanding IMEM fetch sequencer with a
// one-entry valid/ready output slot, redirect flush and halt.  Rev 1.0
`default_nettype none

module fetch_sequencer #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              halt,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ack,
  input  logic [DATA_W-1:0] imem_rdata,
  output logic              inst_valid,
  input  logic              inst_ready,
  output logic [DATA_W-1:0] inst_data,
  output logic [ADDR_W-1:0] inst_pc,
  output logic [ADDR_W-1:0] pc_current,
  output logic [ADDR_W-1:0] pc_next
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_DRAIN = 2'd3
  } state_t;

  state_t            state;
  logic [ADDR_W-1:0] pc;
  logic [ADDR_W-1:0] redirect_aligned;
  logic              slot_free;
  logic              ack_pending;

  assign redirect_aligned = redirect_pc & ~ADDR_W'(3);
  assign slot_free        = !inst_valid || inst_ready;
  assign ack_pending      = (state == S_WAIT) || (state == S_DRAIN);

  // A redirect in ISSUE suppresses the request so the old PC is never fetched.
  assign imem_req   = !reset && (state == S_ISSUE) && !halt && !redirect_valid && slot_free;
  assign imem_addr  = pc;
  assign pc_current = pc;
  assign pc_next    = pc + ADDR_W'(4);

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= S_IDLE;
      pc         <= RESET_PC;
      inst_valid <= 1'b0;
      inst_data  <= '0;
      inst_pc    <= '0;
    end else begin
      if (inst_valid && inst_ready)
        inst_valid <= 1'b0;

      if (redirect_valid) begin
        pc         <= redirect_aligned;
        inst_valid <= 1'b0;
        // An ack arriving with the redirect retires the stale request at once.
        state      <= (ack_pending && !imem_ack) ? S_DRAIN : S_ISSUE;
      end else begin
        case (state)
          S_IDLE:  state <= S_ISSUE;
          S_ISSUE: if (imem_req) state <= S_WAIT;
          S_WAIT: begin
            if (imem_ack) begin
              inst_data  <= imem_rdata;
              inst_pc    <= pc;
              inst_valid <= 1'b1;
              pc         <= pc_next;
              state      <= S_ISSUE;
            end
          end
          S_DRAIN: if (imem_ack) state <= S_ISSUE;
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

`default_nettype wire
